// File: rtl/mips_mem_pkg.sv
// Shared encodings and defaults for the unified-memory port arbiter.
package mips_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int          DEF_ADDR_W    = 32;
    localparam int          DEF_DATA_W    = 32;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles without mem_ready and flags expiry on the last allowed one.
// Expiry is combinational; the count returns to zero whenever the arbiter leaves BUSY.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Every BUSY is preceded by IDLE, so clearing outside BUSY restarts it on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (!i_busy) begin
            r_cnt <= 8'd0;
        end else if (!i_ready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = i_busy & ~i_ready & (r_cnt == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for one single-port memory: request -> done in 2 cycles + wait states,
// stall held while either side is outstanding. Optional BUSY timeout via MEM_TIMEOUT_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              r_st,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err,
    output logic              stall
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 2..255");
    end

    state_t              r_state;
    state_t              w_next;
    owner_t              r_owner;
    owner_t              w_owner_next;
    logic                w_busy;
    logic                w_timeout;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    assign w_busy = (r_state == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
    logic r_bus_err;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (r_st),
        .i_busy    (w_busy),
        .i_ready   (mem_ready),
        .o_expired (w_timeout)
    );

    // Registered so the pulse lines up with the DONE cycle of the aborted access.
    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_I;
        end else begin
            r_state <= w_next;
            r_owner <= w_owner_next;
        end
    end

    // Data side wins a tie: its access belongs to the instruction already in flight.
    always_comb begin
        w_next       = r_state;
        w_owner_next = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_owner_next = OWN_D;
                    w_next       = ST_BUSY;
                end else if (i_req) begin
                    w_owner_next = OWN_I;
                    w_next       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_busy) begin
            mem_req = 1'b1;
            if (r_owner == OWN_D) begin
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_be   = 4'hF;
                mem_addr = i_addr;
            end
        end
    end

    // A store completion leaves the load-data register untouched.
    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_busy && mem_ready) begin
            if (r_owner == OWN_I) begin
                r_i_rdata <= mem_rdata;
            end else if (!d_we) begin
                r_d_rdata <= mem_rdata;
            end
        end else if (w_timeout) begin
            if (r_owner == OWN_I) begin
`ifdef MEM_TIMEOUT_EN
                r_i_rdata <= DATA_W'(TIMEOUT_RDATA);
`else
                r_i_rdata <= '0;
`endif
            end else begin
`ifdef MEM_TIMEOUT_EN
                r_d_rdata <= DATA_W'(TIMEOUT_RDATA);
`else
                r_d_rdata <= '0;
`endif
            end
        end
    end

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_done  = (r_state == ST_DONE) && (r_owner == OWN_I);
    assign d_done  = (r_state == ST_DONE) && (r_owner == OWN_D);
    assign stall   = ~r_st & ((i_req & ~i_done) | (d_req & ~d_done));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout checks follow MEM_TIMEOUT_EN (TIMEOUT=4 when set).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        r_st;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic        stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .r_st      (r_st),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err),
        .stall     (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_st = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_i_done", {31'd0, i_done}, 32'd0);
        chk("rst_d_done", {31'd0, d_done}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        i_req = 1'b1;
        #1;
        chk("rst_stall_forced", {31'd0, stall}, 32'd0);
        i_req = 1'b0;
        tick();
        r_st = 1'b0;
        tick();

        // Zero-wait fetch
        i_req = 1'b1; i_addr = 32'h0000_0010; mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        #1;
        chk("f0_stall_c0", {31'd0, stall}, 32'd1);
        chk("f0_mem_req_c0", {31'd0, mem_req}, 32'd0);
        tick();
        chk("f0_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("f0_mem_addr", mem_addr, 32'h0000_0010);
        chk("f0_mem_be", {28'd0, mem_be}, 32'hF);
        chk("f0_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f0_stall_c1", {31'd0, stall}, 32'd1);
        chk("f0_i_done_c1", {31'd0, i_done}, 32'd0);
        tick();
        chk("f0_i_done_c2", {31'd0, i_done}, 32'd1);
        chk("f0_i_rdata", i_rdata, 32'h2008_0005);
        chk("f0_mem_req_c2", {31'd0, mem_req}, 32'd0);
        chk("f0_stall_c2", {31'd0, stall}, 32'd0);
        i_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("f0_i_done_c3", {31'd0, i_done}, 32'd0);
        chk("f0_i_rdata_hold", i_rdata, 32'h2008_0005);

        // Simultaneous store and fetch: store first
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
        i_req = 1'b1; i_addr = 32'h0000_0014; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_be", {28'd0, mem_be}, 32'b0011);
        chk("st_mem_addr", mem_addr, 32'h40);
        chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        tick();
        chk("st_d_done", {31'd0, d_done}, 32'd1);
        chk("st_i_done", {31'd0, i_done}, 32'd0);
        chk("st_d_rdata_kept", d_rdata, 32'd0);
        chk("st_stall_fetch_pending", {31'd0, stall}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("st_idle_gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("fq_mem_req", {31'd0, mem_req}, 32'd1);
        chk("fq_mem_addr", mem_addr, 32'h0000_0014);
        chk("fq_mem_wdata", mem_wdata, 32'd0);
        mem_rdata = 32'h8C00_0044;
        tick();
        chk("fq_i_done", {31'd0, i_done}, 32'd1);
        chk("fq_i_rdata", i_rdata, 32'h8C00_0044);
        i_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Load with three wait states
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF; mem_rdata = 32'h0000_0BAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ld_wait_mem_req", {31'd0, mem_req}, 32'd1);
            chk("ld_wait_d_done", {31'd0, d_done}, 32'd0);
        end
        tick();
        chk("ld_ready_mem_req", {31'd0, mem_req}, 32'd1);
        chk("ld_mem_addr", mem_addr, 32'h80);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ld_d_done_c5", {31'd0, d_done}, 32'd1);
        chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("ld_mem_req_off", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        tick();

        // Asynchronous reset in the middle of a fetch
        i_req = 1'b1; i_addr = 32'h20;
        tick();
        chk("ar_busy", {31'd0, mem_req}, 32'd1);
        #2 r_st = 1'b1;
        #1;
        chk("ar_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("ar_stall_forced", {31'd0, stall}, 32'd0);
        tick();
        chk("ar_no_done", {31'd0, i_done}, 32'd0);
        chk("ar_i_rdata_clr", i_rdata, 32'd0);
        r_st = 1'b0;
        tick();
        chk("ar_regrant", {31'd0, mem_req}, 32'd1);
        chk("ar_regrant_addr", mem_addr, 32'h20);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("ar_i_done", {31'd0, i_done}, 32'd1);
        chk("ar_i_rdata", i_rdata, 32'h1234_5678);
        i_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Load with memory never ready
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_be = 4'hF; mem_rdata = 32'h5555_5555;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("to_mem_req", {31'd0, mem_req}, 32'd1);
            chk("to_bus_err_low", {31'd0, bus_err}, 32'd0);
        end
        tick();
        chk("to_d_done", {31'd0, d_done}, 32'd1);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_d_rdata", d_rdata, 32'd0);
        chk("to_mem_req_off", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("nt_mem_req", {31'd0, mem_req}, 32'd1);
            chk("nt_bus_err", {31'd0, bus_err}, 32'd0);
            chk("nt_d_done", {31'd0, d_done}, 32'd0);
        end
        r_st = 1'b1;
        d_req = 1'b0;
        tick();
        r_st = 1'b0;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
